// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: entry layout, the no-exception code
// and branch/jump decode used by the delay-slot hold.
package iq_pkg;
   localparam int unsigned IQ_IEXCEP_W = 2;
   localparam logic [IQ_IEXCEP_W-1:0] IEXCEP_NONE = 2'd1;

   typedef struct packed {
      logic [31:0]            inst;
      logic [31:0]            pc;
      logic [IQ_IEXCEP_W-1:0] iexcep;
   } iq_entry_t;

   // True for any instruction that owns a delay slot.
   function automatic logic is_branch(input logic [31:0] inst);
      logic [5:0] op;
      logic [5:0] funct;
      op    = inst[31:26];
      funct = inst[5:0];
      return (op == 6'b000001) || (op == 6'b000010) || (op == 6'b000011) ||
             (op[5:2] == 4'b0001) ||
             ((op == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001)));
   endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: enqueue lanes from fetch, head window and commit count to issue.
interface fetch_queue_if #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned FETCH_W  = 2,
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned IEXCEP_W = 2
);
   logic                              flush;
   logic [FETCH_W-1:0]                enq_valid;
   logic [FETCH_W-1:0][31:0]          enq_inst;
   logic [31:0]                       enq_pc;
   logic [IEXCEP_W-1:0]               enq_iexcep;
   logic                              enq_ready;
   logic [ISSUE_W-1:0]                deq_valid;
   logic [ISSUE_W-1:0][31:0]          deq_inst;
   logic [ISSUE_W-1:0][31:0]          deq_pc;
   logic [ISSUE_W-1:0][IEXCEP_W-1:0]  deq_iexcep;
   logic [$clog2(ISSUE_W+1)-1:0]      deq_count;
   logic [$clog2(DEPTH):0]            occupancy;

   modport master (
      output flush, enq_valid, enq_inst, enq_pc, enq_iexcep, deq_count,
      input  enq_ready, deq_valid, deq_inst, deq_pc, deq_iexcep, occupancy
   );

   modport slave (
      input  flush, enq_valid, enq_inst, enq_pc, enq_iexcep, deq_count,
      output enq_ready, deq_valid, deq_inst, deq_pc, deq_iexcep, occupancy
   );
endinterface

// File: rtl/fetch_queue_window.sv
// Combinational head-window extraction: wrap indexing, delay-slot hold and the
// optional same-cycle bypass source select.
module fetch_queue_window
   import iq_pkg::*;
#(
   parameter  int unsigned DEPTH    = 16,
   parameter  int unsigned FETCH_W  = 2,
   parameter  int unsigned ISSUE_W  = 2,
   parameter  int unsigned IEXCEP_W = 2,
   localparam int unsigned PTR_W    = $clog2(DEPTH),
   localparam int unsigned CNT_W    = PTR_W + 1
) (
   input  iq_entry_t                         mem [DEPTH],
   input  logic [PTR_W-1:0]                  rd_ptr,
   input  logic [CNT_W-1:0]                  count,
   input  logic                              byp_sel,
   input  iq_entry_t                         byp_lanes [FETCH_W],
   input  logic [CNT_W-1:0]                  byp_n,
   output logic [ISSUE_W-1:0]                deq_valid,
   output logic [ISSUE_W-1:0][31:0]          deq_inst,
   output logic [ISSUE_W-1:0][31:0]          deq_pc,
   output logic [ISSUE_W-1:0][IEXCEP_W-1:0]  deq_iexcep,
   output logic [CNT_W-1:0]                  n_valid
);
   iq_entry_t        lane_e [ISSUE_W];
   logic [CNT_W-1:0] avail;
   logic [CNT_W-1:0] n_win;
   logic             hold;

   always_comb begin
      avail = byp_sel ? byp_n : count;
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         lane_e[i] = mem[rd_ptr + PTR_W'(i)];
         if (byp_sel) lane_e[i] = (i < FETCH_W) ? byp_lanes[i % FETCH_W] : '0;
      end
      n_win = (avail > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : avail;
      // Hold only when the window reaches the tail: beyond it, the slot is already queued.
      hold = 1'b0;
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         if ((CNT_W'(i) + 1'b1 == n_win) && (avail <= CNT_W'(ISSUE_W)))
            hold = is_branch(lane_e[i].inst);
      end
      n_valid = n_win - CNT_W'(hold);
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         deq_valid[i]  = CNT_W'(i) < n_valid;
         deq_inst[i]   = deq_valid[i] ? lane_e[i].inst   : '0;
         deq_pc[i]     = deq_valid[i] ? lane_e[i].pc     : '0;
         deq_iexcep[i] = deq_valid[i] ? lane_e[i].iexcep : IEXCEP_NONE;
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and issue: storage, pointers and count.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import iq_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned FETCH_W  = 2,
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned IEXCEP_W = IQ_IEXCEP_W
) (
   input logic          clk,
   input logic          aresetn,
   fetch_queue_if.slave q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   iq_entry_t        mem_q [DEPTH];
   iq_entry_t        mem_d [DEPTH];
   iq_entry_t        lanes [FETCH_W];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] n_enq, n_deq, n_valid, store_off, n_store, rd_adv;
   logic             enq_fire, byp_sel;

   always_comb begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         lanes[i].inst   = q.enq_inst[i];
         lanes[i].pc     = q.enq_pc + 32'(4 * i);
         lanes[i].iexcep = (i == 0) ? q.enq_iexcep : IEXCEP_NONE;
      end
   end

   assign q.enq_ready = count_q <= CNT_W'(DEPTH - FETCH_W);
   assign q.occupancy = count_q;
   assign enq_fire    = q.enq_ready & q.enq_valid[0] & ~q.flush;
   assign n_enq       = enq_fire ? CNT_W'($countones(q.enq_valid)) : '0;
   assign n_deq       = q.flush ? '0 :
                        ((CNT_W'(q.deq_count) > n_valid) ? n_valid : CNT_W'(q.deq_count));

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp_sel = (count_q == '0) & enq_fire;
`else
   assign byp_sel = 1'b0;
`endif

   fetch_queue_window #(
      .DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .IEXCEP_W(IEXCEP_W)
   ) u_window (
      .mem(mem_q), .rd_ptr(rd_ptr_q), .count(count_q),
      .byp_sel(byp_sel), .byp_lanes(lanes), .byp_n(n_enq),
      .deq_valid(q.deq_valid), .deq_inst(q.deq_inst), .deq_pc(q.deq_pc),
      .deq_iexcep(q.deq_iexcep), .n_valid(n_valid)
   );

   // Bypassed lanes consumed this cycle are skipped; the remainder lands at wr_ptr.
   always_comb begin
      store_off = byp_sel ? n_deq : '0;
      n_store   = n_enq - store_off;
      rd_adv    = byp_sel ? '0 : n_deq;
      mem_d     = mem_q;
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         if ((CNT_W'(i) >= store_off) && (CNT_W'(i) < n_enq))
            mem_d[wr_ptr_q + PTR_W'(i) - PTR_W'(store_off)] = lanes[i];
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(n_store);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_adv);
      count_d  = count_q + n_enq - n_deq;
      if (q.flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assert property (@(posedge clk) disable iff (!aresetn)
      (q.enq_valid & (q.enq_valid + FETCH_W'(1))) == '0);
   assert property (@(posedge clk) disable iff (!aresetn)
      q.flush || (CNT_W'(q.deq_count) <= n_valid));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, no bypass).
module tb_fetch_queue;
   import iq_pkg::*;

   logic clk = 1'b0;
   logic aresetn;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fetch_queue_if #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2), .IEXCEP_W(2)) ifc ();

   fetch_queue #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2), .IEXCEP_W(2)) dut (
      .clk(clk), .aresetn(aresetn), .q(ifc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic enq(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pc, input logic [1:0] ex);
      ifc.enq_valid   = v;
      ifc.enq_inst[0] = i0;
      ifc.enq_inst[1] = i1;
      ifc.enq_pc      = pc;
      ifc.enq_iexcep  = ex;
   endtask

   // Advance one clock; inputs return to idle right after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      ifc.enq_valid  = '0;
      ifc.flush      = 1'b0;
      ifc.deq_count  = '0;
      ifc.enq_iexcep = 2'd1;
   endtask

   initial begin
      aresetn        = 1'b0;
      ifc.flush      = 1'b0;
      ifc.deq_count  = '0;
      enq(2'b00, 32'h0, 32'h0, 32'h0, 2'd1);
      #2;
      chk("rst_deq_valid", 64'(ifc.deq_valid), 64'h0);
      chk("rst_enq_ready", 64'(ifc.enq_ready), 64'h1);
      chk("rst_occupancy", 64'(ifc.occupancy), 64'h0);
      chk("rst_deq_inst",  64'(ifc.deq_inst),  64'h0);
      chk("rst_deq_iexcep", 64'(ifc.deq_iexcep), 64'h5);
      #10 aresetn = 1'b1;
      cycle();

      // First pair: one-cycle latency.
      enq(2'b11, 32'h24010001, 32'h24020002, 32'hBFC00000, 2'd1);
      cycle();
      chk("first_valid", 64'(ifc.deq_valid), 64'h3);
      chk("first_pc",    64'(ifc.deq_pc),    64'hBFC00004_BFC00000);
      chk("first_inst",  64'(ifc.deq_inst),  64'h24020002_24010001);
      chk("first_occ",   64'(ifc.occupancy), 64'd2);

      // Fill to 14.
      for (int p = 1; p <= 6; p++) begin
         enq(2'b11, 32'h24000000 + 32'(2*p), 32'h24000001 + 32'(2*p),
             32'hBFC00000 + 32'(8*p), 2'd1);
         cycle();
      end
      chk("fill14_occ",   64'(ifc.occupancy), 64'd14);
      chk("fill14_ready", 64'(ifc.enq_ready), 64'h1);

      // Simultaneous enq/deq, write pointer wraps.
      enq(2'b11, 32'h2400000E, 32'h2400000F, 32'hBFC00038, 2'd1);
      ifc.deq_count = 2'd2;
      cycle();
      chk("encdeq_occ", 64'(ifc.occupancy), 64'd14);
      chk("encdeq_pc",  64'(ifc.deq_pc),    64'hBFC0000C_BFC00008);

      enq(2'b01, 32'h24000010, 32'h0, 32'hBFC00040, 2'd1);
      cycle();
      chk("full15_occ",   64'(ifc.occupancy), 64'd15);
      chk("full15_ready", 64'(ifc.enq_ready), 64'h0);

      enq(2'b11, 32'h24000020, 32'h24000021, 32'hBFC00044, 2'd1);
      cycle();
      chk("full_reject_occ", 64'(ifc.occupancy), 64'd15);

      // Drain across the read-pointer wrap.
      for (int k = 1; k <= 7; k++) begin
         ifc.deq_count = 2'd2;
         cycle();
         if (k <= 6)
            chk($sformatf("drain_pc%0d", k), 64'(ifc.deq_pc[0]), 64'(32'hBFC00000 + 32'(8*(k+1))));
         if (k == 6)
            chk("drain_wrap_inst", 64'(ifc.deq_inst), 64'h2400000F_2400000E);
      end
      chk("drain_last_valid", 64'(ifc.deq_valid), 64'h1);
      chk("drain_last_pc",    64'(ifc.deq_pc),    64'h00000000_BFC00040);
      chk("drain_last_occ",   64'(ifc.occupancy), 64'd1);
      ifc.deq_count = 2'd1;
      cycle();
      chk("empty_occ",   64'(ifc.occupancy), 64'd0);
      chk("empty_valid", 64'(ifc.deq_valid), 64'h0);

      // Lone branch is held until its delay slot arrives.
      enq(2'b01, 32'h10000003, 32'h0, 32'h80000000, 2'd1);
      cycle();
      chk("beq_hold_valid", 64'(ifc.deq_valid), 64'h0);
      chk("beq_hold_occ",   64'(ifc.occupancy), 64'd1);
      enq(2'b01, 32'h24030003, 32'h0, 32'h80000004, 2'd1);
      cycle();
      chk("beq_slot_valid", 64'(ifc.deq_valid), 64'h3);
      chk("beq_slot_inst",  64'(ifc.deq_inst),  64'h24030003_10000003);
      ifc.deq_count = 2'd2;
      cycle();

      // JR at the window edge without its slot.
      enq(2'b11, 32'h24040004, 32'h03E00008, 32'h80000100, 2'd1);
      cycle();
      chk("jr_hold_valid", 64'(ifc.deq_valid), 64'h1);
      chk("jr_hold_inst",  64'(ifc.deq_inst),  64'h00000000_24040004);
      enq(2'b01, 32'h00000000, 32'h0, 32'h80000108, 2'd1);
      cycle();
      chk("jr_slot_valid", 64'(ifc.deq_valid), 64'h3);

      // Flush with a same-cycle enqueue at occupancy 6.
      enq(2'b11, 32'h24060006, 32'h24070007, 32'h8000010C, 2'd1);
      cycle();
      enq(2'b01, 32'h24080008, 32'h0, 32'h80000114, 2'd1);
      cycle();
      chk("preflush_occ", 64'(ifc.occupancy), 64'd6);
      enq(2'b11, 32'h24090009, 32'h240A000A, 32'h80000118, 2'd1);
      ifc.flush = 1'b1;
      cycle();
      chk("flush_occ",   64'(ifc.occupancy), 64'd0);
      chk("flush_valid", 64'(ifc.deq_valid), 64'h0);
      cycle();
      chk("flush_discard_occ", 64'(ifc.occupancy), 64'd0);

      // Exception code only on lane 0.
      enq(2'b11, 32'h24050005, 32'h240B000B, 32'h80000200, 2'd2);
      cycle();
      chk("iexcep_lanes", 64'(ifc.deq_iexcep), 64'h6);
      chk("iexcep_pc",    64'(ifc.deq_pc),     64'h80000204_80000200);

      // Asynchronous reset between clock edges.
      #2 aresetn = 1'b0;
      #1;
      chk("async_rst_occ",   64'(ifc.occupancy), 64'd0);
      chk("async_rst_valid", 64'(ifc.deq_valid), 64'h0);
      chk("async_rst_ready", 64'(ifc.enq_ready), 64'h1);
      #10 aresetn = 1'b1;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
